// File: rtl/i2s_tx_serializer_if.sv
// rtl/i2s_tx_serializer_if.sv - sample handshake between the async FIFO and the I2S serializer
interface i2s_tx_serializer_if #(
  parameter int Nb = 24
);
  logic          in_valid;
  logic [Nb-1:0] in_data;
  logic          in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S master transmitter popping one sample per channel slot
module i2s_tx_serializer #(
  parameter int Nb      = 24,
  parameter int SLOT    = 32,
  parameter int BCK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  i2s_tx_serializer_if.slave  smp,
  output logic                bck,
  output logic                lrck,
  output logic                sdata,
  output logic                running,
  output logic [15:0]         underrun_count
);
  localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(BCK_DIV - 2);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] BIT_MID  = BW'(SLOT - 1);
  localparam logic [BW-1:0] SLOT_W   = BW'(SLOT);
  localparam logic [BW-1:0] NB_W     = BW'(Nb);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [Nb-1:0] shreg;
  logic          zero_right;
  logic          in_ready_q;

  logic          div_wrap;
  logic [DW-1:0] div_nxt;
  logic [BW-1:0] bit_nxt;
  logic [BW-1:0] k_nxt;
  logic          at_right;
  logic          at_end;
  logic          pre_load;
  logic          load;
  logic          take;
  logic [15:0]   uc_inc;

  assign smp.in_ready = in_ready_q;

  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    div_nxt  = div_wrap ? '0 : div_cnt + 1'b1;
    bit_nxt  = bit_cnt;
    if (div_wrap) begin
      bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end
    k_nxt    = (bit_nxt >= SLOT_W) ? bit_nxt - SLOT_W : bit_nxt;
    at_right = (bit_cnt == BIT_MID);
    at_end   = (bit_cnt == BIT_LAST);
    pre_load = (div_cnt == DIV_PRE) && (at_right || at_end);
    load     = div_wrap && (at_right || at_end);
    take     = in_ready_q && smp.in_valid;
    uc_inc   = (underrun_count == 16'hFFFF) ? underrun_count : underrun_count + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      zero_right     <= 1'b0;
      in_ready_q     <= 1'b0;
      bck            <= 1'b0;
      lrck           <= 1'b0;
      sdata          <= 1'b0;
      running        <= 1'b0;
      underrun_count <= '0;
    end else begin
      in_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          bck     <= 1'b0;
          lrck    <= 1'b0;
          sdata   <= 1'b0;
          running <= 1'b0;
          if (enable) begin
            state      <= PRIME;
            in_ready_q <= 1'b1;
          end
        end
        PRIME: begin
          state      <= RUN;
          running    <= 1'b1;
          div_cnt    <= '0;
          bit_cnt    <= '0;
          shreg      <= take ? smp.in_data : '0;
          zero_right <= !take;
          if (!take) underrun_count <= uc_inc;
        end
        RUN: begin
          div_cnt <= div_nxt;
          bit_cnt <= bit_nxt;
          bck     <= (div_nxt >= DIV_HALF);
          lrck    <= (bit_nxt >= SLOT_W);
          // in_ready is registered, so the pop is requested one clk ahead of the load cycle
          if (pre_load) in_ready_q <= at_right ? !zero_right : enable;
          if (div_wrap) begin
            if ((k_nxt != '0) && (k_nxt <= NB_W)) begin
              sdata <= shreg[Nb-1];
              shreg <= {shreg[Nb-2:0], 1'b0};
            end else begin
              sdata <= 1'b0;
            end
          end
          if (load) begin
            if (at_end && !in_ready_q) begin
              state   <= IDLE;
              running <= 1'b0;
              bck     <= 1'b0;
              lrck    <= 1'b0;
              sdata   <= 1'b0;
              div_cnt <= '0;
              bit_cnt <= '0;
            end else if (at_right && zero_right) begin
              // left slot underran: silence the partner right slot without popping
              shreg          <= '0;
              zero_right     <= 1'b0;
              underrun_count <= uc_inc;
            end else begin
              shreg <= take ? smp.in_data : '0;
              if (!take) underrun_count <= uc_inc;
              if (at_end) zero_right <= !take;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - directed bench for i2s_tx_serializer
module tb_i2s_tx_serializer;
  localparam int Nb = 24, SLOT = 32, BCK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        bck, lrck, sdata, running;
  logic [15:0] underrun_count;

  i2s_tx_serializer_if #(.Nb(Nb)) smp ();

  i2s_tx_serializer #(.Nb(Nb), .SLOT(SLOT), .BCK_DIV(BCK_DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .smp(smp),
    .bck(bck), .lrck(lrck), .sdata(sdata), .running(running),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  logic [23:0] fifo [$];
  bit hs_pending = 0;
  int pulses [$];
  int ir_cycles, run_start, bitcnt, pmin, pmax, last_rise, sd_bad, p;
  bit rise_valid = 0;
  logic [31:0] rx_word [$];
  logic rx_lr [$];
  int lr_rise [$], lr_fall [$];
  logic [31:0] shw = '0;
  logic slot_lr = 1'b0;
  logic prev_ir = 0, prev_run = 0, prev_bck = 0, prev_lr = 0, prev_sd = 0;
  int exp_pulse [$];
  logic [23:0] exp_samp [$];
  logic [23:0] tbl [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [23:0] s);
    return {1'b0, s, 7'b0};
  endfunction

  task automatic clear_obs();
    pulses.delete(); rx_word.delete(); rx_lr.delete();
    lr_rise.delete(); lr_fall.delete();
    ir_cycles = 0; bitcnt = 0; pmin = 1000; pmax = 0; sd_bad = 0; run_start = -1000;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!running && n < 50) begin @(negedge clk); n++; end
    check_eq({tag, " start"}, {31'b0, running}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_stop(input string tag);
    int n = 0;
    while (running && n < 800) begin @(negedge clk); n++; end
    check_eq({tag, " stopped"}, {31'b0, running}, 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_stream(input string tag);
    check_eq({tag, " pulses"}, pulses.size(), exp_pulse.size());
    check_eq({tag, " ready_cycles"}, ir_cycles, exp_pulse.size());
    foreach (exp_pulse[i])
      if (i < pulses.size())
        check_eq($sformatf("%s pulse%0d", tag, i), pulses[i] - run_start, exp_pulse[i]);
    check_eq({tag, " slots"}, rx_word.size(), exp_samp.size());
    foreach (exp_samp[i])
      if (i < rx_word.size()) begin
        check_eq($sformatf("%s word%0d", tag, i), rx_word[i], fmt(exp_samp[i]));
        check_eq($sformatf("%s lr%0d", tag, i), {31'b0, rx_lr[i]}, i % 2);
      end
    check_eq({tag, " sdata_edges"}, sd_bad, 0);
    check_eq({tag, " idle_out"}, {28'b0, smp.in_ready, bck, lrck, sdata}, 32'd0);
  endtask

  // FIFO model plus wire-level receiver, all sampled on the falling edge
  initial begin
    smp.in_valid = 1'b0;
    smp.in_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (hs_pending && fifo.size() > 0) void'(fifo.pop_front());
      smp.in_valid = (fifo.size() > 0);
      smp.in_data  = (fifo.size() > 0) ? fifo[0] : '0;
      hs_pending   = smp.in_ready && smp.in_valid;
      if (smp.in_ready) begin
        ir_cycles++;
        if (!prev_ir) pulses.push_back(cyc);
      end
      if (running && !prev_run) run_start = cyc;
      if (!running) rise_valid = 0;
      if (bck && !prev_bck) begin
        if (rise_valid) begin
          p = cyc - last_rise;
          if (p < pmin) pmin = p;
          if (p > pmax) pmax = p;
        end
        last_rise = cyc; rise_valid = 1;
        if (bitcnt == 0) slot_lr = lrck;
        shw = {shw[30:0], sdata};
        bitcnt++;
        if (bitcnt == 32) begin
          rx_word.push_back(shw); rx_lr.push_back(slot_lr); bitcnt = 0;
        end
      end
      if (lrck && !prev_lr) lr_rise.push_back(cyc);
      if (!lrck && prev_lr) lr_fall.push_back(cyc);
      if ((sdata != prev_sd) && !(prev_bck && !bck)) sd_bad++;
      prev_ir = smp.in_ready; prev_run = running; prev_bck = bck;
      prev_lr = lrck; prev_sd = sdata;
    end
  end

  initial begin
    tbl = '{24'h800001, 24'h7FFFFE, 24'h123456, 24'hABCDEF, 24'h000000, 24'hFFFFFF,
            24'hA5A5A5, 24'h5A5A5A, 24'h000001, 24'h800000, 24'hC3C3C3, 24'h3C3C3C,
            24'h0F0F0F, 24'hF0F0F0, 24'h7F0001, 24'h80FFFE};
    clear_obs();
    repeat (3) @(negedge clk);
    check_eq("rst in_ready", {31'b0, smp.in_ready}, 0);
    check_eq("rst bck", {31'b0, bck}, 0);
    check_eq("rst lrck", {31'b0, lrck}, 0);
    check_eq("rst sdata", {31'b0, sdata}, 0);
    check_eq("rst running", {31'b0, running}, 0);
    check_eq("rst underrun", {16'b0, underrun_count}, 0);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    // eight continuous frames, stop requested mid left slot of the last one
    clear_obs();
    for (int i = 0; i < 16; i++) fifo.push_back(tbl[i]);
    enable = 1'b1;
    wait_start("A");
    wait_until(run_start + 7 * 256 + 64);
    enable = 1'b0;
    wait_stop("A");
    exp_pulse.delete(); exp_samp.delete();
    for (int i = 0; i < 16; i++) begin
      exp_pulse.push_back((i == 0) ? -1 : 128 * i - 1);
      exp_samp.push_back(tbl[i]);
    end
    check_stream("A");
    check_eq("A first_left", (rx_word.size() > 0) ? rx_word[0] : 32'hDEADBEEF, 32'h40000080);
    check_eq("A first_right", (rx_word.size() > 1) ? rx_word[1] : 32'hDEADBEEF, 32'h3FFFFF00);
    check_eq("A lrck_rises", lr_rise.size(), 8);
    check_eq("A lrck_falls", lr_fall.size(), 8);
    check_eq("A lrck_rise0", (lr_rise.size() > 0) ? lr_rise[0] - run_start : -1, 128);
    check_eq("A lrck_fall0", (lr_fall.size() > 0) ? lr_fall[0] - run_start : -1, 256);
    check_eq("A frame_span", (lr_rise.size() > 7) ? lr_rise[7] - lr_rise[0] : -1, 7 * 256);
    check_eq("A bck_pmin", pmin, 4);
    check_eq("A bck_pmax", pmax, 4);
    check_eq("A underrun", {16'b0, underrun_count}, 0);

    // FIFO empty at the second left load
    clear_obs();
    fifo.push_back(24'hC00003); fifo.push_back(24'h00FF00);
    enable = 1'b1;
    wait_start("B");
    wait_until(run_start + 300);
    fifo.push_back(24'h123ABC); fifo.push_back(24'hFEDCBA);
    wait_until(run_start + 2 * 256 + 64);
    enable = 1'b0;
    wait_stop("B");
    exp_pulse = '{-1, 127, 255, 511, 639};
    exp_samp  = '{24'hC00003, 24'h00FF00, 24'h000000, 24'h000000, 24'h123ABC, 24'hFEDCBA};
    check_stream("B");
    check_eq("B underrun", {16'b0, underrun_count}, 2);

    // FIFO empty at a right load only
    clear_obs();
    fifo.push_back(24'h5A5A5A);
    enable = 1'b1;
    wait_start("C");
    wait_until(run_start + 140);
    fifo.push_back(24'h0F0F0F); fifo.push_back(24'hF0F0F0);
    wait_until(run_start + 256 + 64);
    enable = 1'b0;
    wait_stop("C");
    exp_pulse = '{-1, 127, 255, 383};
    exp_samp  = '{24'h5A5A5A, 24'h000000, 24'h0F0F0F, 24'hF0F0F0};
    check_stream("C");
    check_eq("C underrun", {16'b0, underrun_count}, 3);

    // asynchronous reset in the middle of the right slot, then restart
    clear_obs();
    fifo.push_back(24'h111111); fifo.push_back(24'h222222);
    fifo.push_back(24'h333333); fifo.push_back(24'h444444);
    enable = 1'b1;
    wait_start("D");
    wait_until(run_start + 128 + 40);
    check_eq("D lrck_before", {31'b0, lrck}, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("D rst in_ready", {31'b0, smp.in_ready}, 0);
    check_eq("D rst bck", {31'b0, bck}, 0);
    check_eq("D rst lrck", {31'b0, lrck}, 0);
    check_eq("D rst sdata", {31'b0, sdata}, 0);
    check_eq("D rst running", {31'b0, running}, 0);
    check_eq("D rst underrun", {16'b0, underrun_count}, 0);
    @(negedge clk);
    #3;
    fifo.delete(); hs_pending = 0;
    clear_obs();
    fifo.push_back(24'h123456); fifo.push_back(24'hABCDEF);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    wait_start("E");
    wait_until(run_start + 64);
    enable = 1'b0;
    wait_stop("E");
    exp_pulse = '{-1, 127};
    exp_samp  = '{24'h123456, 24'hABCDEF};
    check_stream("E");
    check_eq("E underrun", {16'b0, underrun_count}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Sits directly downstream of the async sample FIFO on the DAC clock domain; pops one signed sample per channel slot and shifts it out as an I2S stream (BCK, LRCK, SDATA) to a DAC.
- Master mode: BCK and LRCK are derived from clk.
- Underruns insert silence and are counted, with L/R pairing preserved.

Parameters:
- Nb, 24, sample width in bits (MSB first on the wire).
- SLOT, 32, BCK periods per channel slot; must be >= Nb+1.
- BCK_DIV, 4, clk cycles per BCK period; even, >= 2.

Ports:
- clk  input  1  DAC-domain clock; the FIFO read clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  start/stop streaming.
- in_valid  input  1  FIFO output valid.
- in_data  input  Nb  FIFO output sample.
- in_ready  output  1  pop strobe to FIFO.
- bck  output  1  I2S bit clock.
- lrck  output  1  word select (0 = left, 1 = right).
- sdata  output  1  serial data.
- running  output  1  high while in RUN.
- underrun_count  output  16  saturating count of slots filled with silence.

Behaviour:
- All outputs are registered.
- Reset (reset=0, async): state=IDLE; in_ready, bck, lrck, sdata, running = 0; underrun_count = 0; internal counters cleared. Reset mid-frame aborts immediately with no partial-frame completion.
- Counters:
  - div_cnt runs 0..BCK_DIV-1.
  - bit_cnt runs 0..2*SLOT-1 and advances when div_cnt wraps.
  - bck = 1 iff div_cnt >= BCK_DIV/2, so falling edges occur at div_cnt = 0.
  - lrck = 1 iff bit_cnt >= SLOT.
- Wire format (I2S):
  - sdata changes only when div_cnt = 0.
  - In each slot, bit position k (k = bit_cnt mod SLOT) carries sample bit Nb-k for k in 1..Nb, and 0 otherwise.
  - The MSB is therefore delayed one BCK after the LRCK edge.
- FSM:
  - IDLE: outputs low, counters held at 0. enable=1 -> PRIME.
  - PRIME (one cycle): in_ready=1 to load the left sample. -> RUN with div_cnt = bit_cnt = 0 and running=1.
  - RUN: a load cycle occurs at div_cnt = BCK_DIV-1 with bit_cnt = SLOT-1 (right load) or bit_cnt = 2*SLOT-1 (next left load). in_ready is high for exactly that one cycle.
  - RUN, stop: at the right-slot end (bit_cnt = 2*SLOT-1, div_cnt = BCK_DIV-1), if enable=0 -> IDLE with no left load (in_ready stays 0). Otherwise the frame is always completed, so disabling never splits an L/R pair.
- Handshake:
  - A sample transfers when in_ready and in_valid are both high; in_data is captured into the shift register that cycle.
  - The FIFO presents its next word afterwards. Only the handshake cycle samples in_data.
- Underrun (in_ready=1, in_valid=0):
  - The slot is loaded with zeros and underrun_count increments, saturating at 65535.
  - If the underrun hits a left load, the following right load of the same frame is forced to zero, in_ready stays 0 for it, and underrun_count increments again.
  - This keeps channel alignment.
  - An underrun on a right load affects only that slot.
- enable toggling while in PRIME is ignored; the machine proceeds to RUN.

Test Plan:
- Nb=24, SLOT=32, BCK_DIV=4; push L=0x800001, R=0x7FFFFE and set enable=1 -> in_ready pulses in PRIME and at clk 127 of the frame. lrck is low for 128 clk, then high for 128. sdata shows 1,0…0,1 in slots 1..24 of left and 0,1…1,0 in slots 1..24 of right. Slot 0 and slots 25..31 are 0.
- Continuous FIFO traffic of 8 frames -> exactly 16 in_ready pulses, and bck period is 4 clk throughout. Frame period 256 clk; no underruns counted.
- Empty FIFO at the second left load -> both slots of that frame output 0, underrun_count=2, and only one in_ready pulse is issued for that frame. The next frame resumes with the correct L/R order.
- Empty FIFO at a right load only -> right slot outputs 0, underrun_count=1, and the next left sample is unaffected.
- Deassert enable mid left slot -> right slot completes with its sample, no further in_ready, IDLE reached at frame end, and bck/lrck/sdata held 0.
- Assert reset=0 mid-right-slot -> all outputs 0 immediately (asynchronously) and underrun_count=0. After release with enable=1, PRIME restarts on the left channel.
